// File: rtl/alu_4bit.sv
// Registered 4-bit ALU: opcode S on operands A/B, result F with carry C and zero Z one cycle later.
// Define ALU_OVF_EN to add the registered signed-overflow flag V.
module alu_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] S,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] F,
  output logic       C,
  output logic       Z,
`ifdef ALU_OVF_EN
  output logic       V,
`endif
  output logic       out_valid
);

  localparam logic [2:0] OP_CLR = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // Handshake: in_valid alone qualifies S/A/B at a rising edge; there is no ready,
  // every valid cycle is accepted, and out_valid pulses the following cycle.
  logic [4:0] sum5;
  logic [4:0] diff5;
  logic [3:0] f_d, f_q;
  logic       c_d, c_q;
  logic       z_d, z_q;
  logic       vld_d, vld_q;

  assign sum5  = {1'b0, A} + {1'b0, B};
  assign diff5 = {1'b0, A} - {1'b0, B};  // bit 4 is the borrow

  always_comb begin
    f_d = 4'b0000;
    c_d = 1'b0;
    case (S)
      OP_CLR: begin f_d = 4'b0000;      c_d = 1'b0;     end
      OP_ADD: begin f_d = sum5[3:0];    c_d = sum5[4];  end
      OP_SUB: begin f_d = diff5[3:0];   c_d = diff5[4]; end
      OP_OR:  begin f_d = A | B;        c_d = 1'b0;     end
      OP_AND: begin f_d = A & B;        c_d = 1'b0;     end
      OP_XOR: begin f_d = A ^ B;        c_d = 1'b0;     end
      OP_SHL: begin f_d = {A[2:0], 1'b0}; c_d = A[3];   end
      OP_SHR: begin f_d = {1'b0, A[3:1]}; c_d = A[0];   end
      default: begin f_d = 4'b0000;     c_d = 1'b0;     end
    endcase
    z_d   = (f_d == 4'b0000);
    vld_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q   <= 4'b0000;
      c_q   <= 1'b0;
      z_q   <= 1'b1;
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (in_valid) begin
        f_q <= f_d;
        c_q <= c_d;
        z_q <= z_d;
      end
    end
  end

`ifdef ALU_OVF_EN
  logic v_d, v_q;

  always_comb begin
    v_d = 1'b0;
    case (S)
      OP_ADD:  v_d = (A[3] == B[3]) & (sum5[3]  != A[3]);
      OP_SUB:  v_d = (A[3] != B[3]) & (diff5[3] != A[3]);
      default: v_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
    end else if (in_valid) begin
      v_q <= v_d;
    end
  end

  assign V = v_q;
`endif

  assign F         = f_q;
  assign C         = c_q;
  assign Z         = z_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_alu_4bit.sv
// Bench for alu_4bit: directed tables plus random back-to-back ops checked through an expected queue.
// Expected entries are {F, C, Z, V}; V is checked only when ALU_OVF_EN is defined.
module tb_alu_4bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [2:0] s;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] f;
  logic       c;
  logic       z;
  logic       v_obs;
  logic       out_valid;

  logic [6:0] exp_q[$];
  logic [6:0] exp_e;
  int         total;
  int         bad;

`ifdef ALU_OVF_EN
  logic v;
  assign v_obs = v;
`else
  assign v_obs = 1'b0;
`endif

  alu_4bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .S         (s),
    .A         (a),
    .B         (b),
    .F         (f),
    .C         (c),
    .Z         (z),
`ifdef ALU_OVF_EN
    .V         (v),
`endif
    .out_valid (out_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  function automatic logic [6:0] mask_v(input logic [6:0] e);
    logic [6:0] r;
    r = e;
`ifndef ALU_OVF_EN
    r[0] = 1'b0;
`endif
    return r;
  endfunction

  // Drive one accepted op, queue its expectation, and step to just after the edge.
  task automatic drive_op(input logic [2:0] op, input logic [3:0] oa, input logic [3:0] ob,
                          input logic [6:0] e);
    s        = op;
    a        = oa;
    b        = ob;
    in_valid = 1'b1;
    exp_q.push_back(mask_v(e));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    s        = $urandom_range(0, 7);
    a        = $urandom_range(0, 15);
    b        = $urandom_range(0, 15);
    @(posedge clk);
    #1;
  endtask

  // Independent arithmetic model working on integers.
  function automatic logic [6:0] model(input logic [2:0] op, input logic [3:0] oa,
                                       input logic [3:0] ob);
    int ia, ib, r, sa, sb, sr;
    logic [3:0] rf;
    logic rc, rv;
    ia = int'(oa); ib = int'(ob);
    sa = (ia > 7) ? ia - 16 : ia;
    sb = (ib > 7) ? ib - 16 : ib;
    rc = 1'b0; rv = 1'b0; r = 0;
    case (op)
      3'd0: r = 0;
      3'd1: begin r = ia + ib; rc = (r > 15); sr = sa + sb; rv = (sr > 7) || (sr < -8); end
      3'd2: begin r = ia - ib + 16; rc = (ia < ib); sr = sa - sb; rv = (sr > 7) || (sr < -8); end
      3'd3: r = int'(oa | ob);
      3'd4: r = int'(oa & ob);
      3'd5: r = int'(oa ^ ob);
      3'd6: begin r = ia * 2; rc = (ia >= 8); end
      default: begin r = ia / 2; rc = (ia % 2) == 1; end
    endcase
    rf = 4'(r % 16);
    return {rf, rc, (rf == 4'd0), rv};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    total++;
    if ({f, c, z, v_obs, out_valid} !== 8'b0000_0_1_0_0) begin
      bad++;
      $display("FAIL reset: got F=%b C=%b Z=%b V=%b ov=%b, want F=0000 C=0 Z=1 V=0 ov=0",
               f, c, z, v_obs, out_valid);
    end
    drive_op(3'b000, 4'b0000, 4'b0000, {4'b0000, 1'b0, 1'b1, 1'b0});
    exp_e = exp_q.pop_front();
    total++;
    if (out_valid !== 1'b1 || {f, c, z, v_obs} !== exp_e) begin
      bad++;
      $display("FAIL clear: got F=%b C=%b Z=%b V=%b ov=%b, want %b ov=1",
               f, c, z, v_obs, out_valid, exp_e);
    end
  endtask

  // Table entries: {S, A, B, F, C, Z, V}
  task automatic test_arith();
    logic [17:0] tbl [7];
    tbl = '{
      {3'b001, 4'b1001, 4'b0111, 4'b0000, 1'b1, 1'b1, 1'b0},
      {3'b001, 4'b0011, 4'b0101, 4'b1000, 1'b0, 1'b0, 1'b1},
      {3'b001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0},
      {3'b010, 4'b1010, 4'b0101, 4'b0101, 1'b0, 1'b0, 1'b1},
      {3'b010, 4'b0111, 4'b0111, 4'b0000, 1'b0, 1'b1, 1'b0},
      {3'b010, 4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0},
      {3'b010, 4'b0010, 4'b0100, 4'b1110, 1'b1, 1'b0, 1'b0}
    };
    for (int i = 0; i < 7; i++) begin
      drive_op(tbl[i][17:15], tbl[i][14:11], tbl[i][10:7], tbl[i][6:0]);
      exp_e = exp_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || {f, c, z, v_obs} !== exp_e) begin
        bad++;
        $display("FAIL arith[%0d]: got F=%b C=%b Z=%b V=%b ov=%b, want %b ov=1",
                 i, f, c, z, v_obs, out_valid, exp_e);
      end
    end
  endtask

  task automatic test_logic_shift();
    logic [17:0] tbl [9];
    tbl = '{
      {3'b011, 4'b1010, 4'b0101, 4'b1111, 1'b0, 1'b0, 1'b0},
      {3'b100, 4'b1010, 4'b1100, 4'b1000, 1'b0, 1'b0, 1'b0},
      {3'b101, 4'b1111, 4'b1010, 4'b0101, 1'b0, 1'b0, 1'b0},
      {3'b110, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0},
      {3'b110, 4'b1111, 4'b0000, 4'b1110, 1'b1, 1'b0, 1'b0},
      {3'b110, 4'b1000, 4'b0110, 4'b0000, 1'b1, 1'b1, 1'b0},
      {3'b111, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0},
      {3'b111, 4'b1111, 4'b0000, 4'b0111, 1'b1, 1'b0, 1'b0},
      {3'b111, 4'b0001, 4'b1001, 4'b0000, 1'b1, 1'b1, 1'b0}
    };
    for (int i = 0; i < 9; i++) begin
      drive_op(tbl[i][17:15], tbl[i][14:11], tbl[i][10:7], tbl[i][6:0]);
      exp_e = exp_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || {f, c, z, v_obs} !== exp_e) begin
        bad++;
        $display("FAIL logic_shift[%0d]: got F=%b C=%b Z=%b V=%b ov=%b, want %b ov=1",
                 i, f, c, z, v_obs, out_valid, exp_e);
      end
    end
  endtask

  task automatic test_hold();
    drive_op(3'b001, 4'b0001, 4'b0001, {4'b0010, 1'b0, 1'b0, 1'b0});
    exp_e = exp_q.pop_front();
    total++;
    if (out_valid !== 1'b1 || {f, c, z, v_obs} !== exp_e) begin
      bad++;
      $display("FAIL hold_load: got F=%b C=%b Z=%b V=%b ov=%b, want %b ov=1",
               f, c, z, v_obs, out_valid, exp_e);
    end
    for (int i = 0; i < 2; i++) begin
      idle_cycle();
      total++;
      if (out_valid !== 1'b0 || {f, c, z, v_obs} !== 7'b0010_0_0_0) begin
        bad++;
        $display("FAIL hold[%0d]: got F=%b C=%b Z=%b V=%b ov=%b, want 0010000 ov=0",
                 i, f, c, z, v_obs, out_valid);
      end
    end
  endtask

  task automatic test_reset_drop();
    drive_op(3'b001, 4'b0011, 4'b0101, {4'b1000, 1'b0, 1'b0, 1'b1});
    exp_e = exp_q.pop_front();
    total++;
    if (out_valid !== 1'b1 || {f, c, z, v_obs} !== exp_e) begin
      bad++;
      $display("FAIL pre_rst: got F=%b C=%b Z=%b V=%b ov=%b, want %b ov=1",
               f, c, z, v_obs, out_valid, exp_e);
    end
    // Reset wins over a valid op presented on the same edge.
    rst = 1'b1; in_valid = 1'b1; s = 3'b110; a = 4'b1111; b = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    total++;
    if ({f, c, z, v_obs, out_valid} !== 8'b0000_0_1_0_0) begin
      bad++;
      $display("FAIL rst_drop: got F=%b C=%b Z=%b V=%b ov=%b, want F=0000 C=0 Z=1 V=0 ov=0",
               f, c, z, v_obs, out_valid);
    end
    @(posedge clk);
    #1;
    total++;
    if ({f, c, z, v_obs, out_valid} !== 8'b0000_0_1_0_0) begin
      bad++;
      $display("FAIL rst_after: got F=%b C=%b Z=%b V=%b ov=%b, want F=0000 C=0 Z=1 V=0 ov=0",
               f, c, z, v_obs, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    logic [3:0] ra, rb;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      drive_op(op, ra, rb, model(op, ra, rb));
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL b2b[%0d]: expected queue empty", i);
      end else begin
        exp_e = exp_q.pop_front();
        if (out_valid !== 1'b1 || {f, c, z, v_obs} !== exp_e) begin
          bad++;
          $display("FAIL b2b[%0d] S=%b A=%b B=%b: got F=%b C=%b Z=%b V=%b ov=%b, want %b ov=1",
                   i, op, ra, rb, f, c, z, v_obs, out_valid, exp_e);
        end
      end
    end
    idle_cycle();
    total++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got ov=%b queued=%0d, want ov=0 queued=0", out_valid, exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; s = 3'b000; a = 4'b0000; b = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_arith();
    test_logic_shift();
    test_hold();
    test_reset_drop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_4bit.md
# alu_4bit

Registered 4-bit arithmetic/logic unit with a 3-bit opcode, producing a 4-bit result plus carry/borrow and zero flags. It is the datapath execution element of the small processor core: operands and opcode are presented with a valid strobe, and the result with its flags appears on registered outputs one clock later.

## Interface
- No parameters; data width is fixed at 4 bits, opcode width at 3 bits.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies S/A/B for capture this cycle.
- S  input  3  opcode.
- A  input  4  operand A (unsigned).
- B  input  4  operand B (unsigned).
- F  output  4  registered result.
- C  output  1  registered carry / borrow / shifted-out bit.
- Z  output  1  registered zero flag: 1 iff F == 4'b0000.
- out_valid  output  1  high for exactly the cycle after an accepted in_valid.
- V  output  1  registered signed-overflow flag (present only with ALU_OVF_EN).

## Operation
- Opcodes (F, C computed from A, B; Z = (F == 0) for every opcode):
  - 000 Clear: F=0000, C=0 (so Z=1); A, B ignored.
  - 001 Add: {C,F} = A + B (5-bit sum; C = carry out).
  - 010 Sub: F = (A − B) mod 16; C = borrow = 1 iff A < B (unsigned).
  - 011 OR: F = A | B; C=0.
  - 100 AND: F = A & B; C=0.
  - 101 XOR: F = A ^ B; C=0.
  - 110 Shift left: F = {A[2:0],0}; C = A[3]; B ignored.
  - 111 Shift right (logical): F = {0,A[3:1]}; C = A[0]; B ignored.
- Result is computed combinationally from the inputs sampled at the edge; no internal accumulator or feedback between operations.
- Z is derived from the new F value, including after shifts and a wrapped add/sub.

## Timing
- Latency: 1 cycle. On a rising edge with rst=0 and in_valid=1, F/C/Z (and V) load the results of the current S/A/B; out_valid goes 1.
- On a rising edge with rst=0 and in_valid=0: F/C/Z/V hold their previous values; out_valid goes 0.
- Back-to-back in_valid accepted every cycle; no backpressure, no stall.
- Reset (rst=1 at a rising edge, overrides in_valid): F=0000, C=0, Z=1, V=0, out_valid=0. Reset mid-stream discards the operation being captured that edge.
- Outputs change only on clock edges; no combinational path from inputs to outputs.

## Configuration
- ALU_OVF_EN defined: port V exists. For Add, V = (A[3]==B[3]) & (F[3]!=A[3]); for Sub, V = (A[3]!=B[3]) & (F[3]!=A[3]); for all other opcodes V=0. Registered and reset like C.
- ALU_OVF_EN undefined: no V port and no overflow logic; all other behaviour identical.

## Test plan
- Reset, then S=000 A=0000 B=0000 in_valid=1 -> next cycle F=0000 C=0 Z=1 out_valid=1; reset values F=0000 C=0 Z=1 out_valid=0 checked before.
- Add: 1001+0111 -> F=0000 C=1 Z=1 (V=0); 0011+0101 -> F=1000 C=0 Z=0 (V=1 with ALU_OVF_EN); 0000+0000 -> F=0000 C=0 Z=1.
- Sub: 1010−0101 -> F=0101 C=0 Z=0; 0111−0111 -> F=0000 C=0 Z=1; 0000−0001 -> F=1111 C=1 Z=0; 0010−0100 -> F=1110 C=1 Z=0.
- Logic: OR 1010|0101 -> F=1111 C=0; AND 1010&1100 -> F=1000 C=0; XOR 1111^1010 -> F=0101 C=0; all Z=0.
- Shifts: SHL 0000 -> F=0000 C=0 Z=1; SHL 1111 -> F=1110 C=1; SHL 1000 -> F=0000 C=1 Z=1; SHR 0000 -> F=0000 C=0 Z=1; SHR 1111 -> F=0111 C=1; SHR 0001 -> F=0000 C=1 Z=1.
- Handshake: in_valid deasserted for 2 cycles after an Add -> F/C/Z hold, out_valid=0; rst asserted together with in_valid -> outputs take reset values, operation dropped.
